// File: rtl/cnt_capture_fifo_pkg.sv
// Shared sizing and flag types for the counter-capture FIFO.
// Defaults match the 8-bit loadable counter feeding it.
package cnt_capture_fifo_pkg;

  localparam int CNT_W          = 8;
  localparam int CNT_FIFO_DEPTH = 8;
  localparam int CNT_FIFO_AW    = 3;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_flags_t;

  // Sticky flag update: a set condition in the same cycle beats a clear.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/cnt_fifo_mem.sv
// Capture storage: synchronous write port, asynchronous read port for show-ahead.
// Contents are intentionally not reset.
module cnt_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/cnt_capture_fifo.sv
// Captures counter snapshots on a strobe into a circular buffer, popped in order.
// Status outputs derive only from registered state, so cap/rd/CNT never reach them combinationally.
module cnt_capture_fifo
  import cnt_capture_fifo_pkg::*;
#(
  parameter int DATA_W = CNT_W,
  parameter int DEPTH  = CNT_FIFO_DEPTH,
  parameter int ADDR_W = CNT_FIFO_AW
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] CNT,
  input  logic              cap,
  input  logic              rd,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   level_reg, level_next;
  fifo_flags_t       flags_reg, flags_next;
  logic              push, pop;
  logic [DATA_W-1:0] head_data;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LEVEL_FULL);

  // A pop frees the slot a full-buffer push needs, so rd lets cap through when full.
  assign push = cap & (~full | rd);
  assign pop  = rd & ~empty;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    flags_next     = flags_reg;
    flags_next.ovf = sticky_next(flags_reg.ovf, cap & full & ~rd, clr_flags);
    flags_next.udf = sticky_next(flags_reg.udf, rd & empty, clr_flags);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      flags_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      flags_reg <= flags_next;
    end
  end

  cnt_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~res),
    .waddr (wr_ptr_reg),
    .wdata (CNT),
    .raddr (rd_ptr_reg),
    .rdata (head_data)
  );

  assign dout  = empty ? '0 : head_data;
  assign level = level_reg;
  assign ovf   = flags_reg.ovf;
  assign udf   = flags_reg.udf;

endmodule

// File: tb/tb_cnt_capture_fifo.sv
// Bench for cnt_capture_fifo: a modelled 8-bit counter drives CNT, and a queue model
// of the capture buffer is compared against every output after every clock edge.
module tb_cnt_capture_fifo;
  import cnt_capture_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] CNT = 8'h00;
  logic       cap = 1'b0;
  logic       rd = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] dout;
  logic       empty, full, ovf, udf;
  logic [3:0] level;

  cnt_capture_fifo dut (
    .clk       (clk),
    .res       (res),
    .CNT       (CNT),
    .cap       (cap),
    .rd        (rd),
    .clr_flags (clr_flags),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  // counter model (count8b) and FIFO reference model
  logic [7:0] count8b = 8'h00;
  logic       cnt_en = 1'b0;
  logic       cnt_ld = 1'b0;
  logic [7:0] cnt_ld_val = 8'h00;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full",  {31'd0, full},  {31'd0, q.size() == CNT_FIFO_DEPTH});
    chk("level", {28'd0, level}, q.size());
    chk("dout",  {24'd0, dout},  (q.size() == 0) ? 32'd0 : {24'd0, q[0]});
    chk("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
    chk("udf",   {31'd0, udf},   {31'd0, m_udf});
  endtask

  task automatic step(input logic c, input logic r, input logic cf, input logic rs);
    bit was_full, was_empty;
    cap = c; rd = r; clr_flags = cf; res = rs; CNT = count8b;
    was_full  = (q.size() == CNT_FIFO_DEPTH);
    was_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (r && !was_empty) void'(q.pop_front());
      if (c && (!was_full || r)) q.push_back(count8b);
      if (c && was_full && !r) m_ovf = 1'b1;
      else if (cf)             m_ovf = 1'b0;
      if (r && was_empty)      m_udf = 1'b1;
      else if (cf)             m_udf = 1'b0;
    end
    @(posedge clk);
    if (cnt_ld)      count8b = cnt_ld_val;
    else if (cnt_en) count8b = count8b + 8'd1;
    #1;
    CNT = count8b;
    check_all();
  endtask

  initial begin
    // 1: reset two cycles, then idle
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_dout", {24'd0, dout}, 32'h00);

    // 2: counter from 0, three captures then three pops
    cnt_ld = 1; cnt_ld_val = 8'h00; step(0, 0, 0, 0); cnt_ld = 0;
    cnt_en = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("t2_head", {24'd0, dout}, 32'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // 3: nine captures from 0, ninth dropped, drain, clear flags
    cnt_en = 0; cnt_ld = 1; cnt_ld_val = 8'h00; step(0, 0, 0, 0); cnt_ld = 0;
    cnt_en = 1;
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);

    // 4: fill, then simultaneous push/pop on a full buffer, then drain
    cnt_en = 0; cnt_ld = 1; cnt_ld_val = 8'h00; step(0, 0, 0, 0); cnt_ld = 0;
    cnt_en = 1;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("t4_level", {28'd0, level}, 32'd8);
    chk("t4_head", {24'd0, dout}, 32'h04);
    cnt_en = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

    // 5: pop while empty with simultaneous capture of a loaded count
    cnt_ld = 1; cnt_ld_val = 8'h11; step(0, 0, 1, 0); cnt_ld = 0;
    step(1, 1, 0, 0);
    chk("t5_udf", {31'd0, udf}, 32'd1);
    chk("t5_level", {28'd0, level}, 32'd1);
    chk("t5_dout", {24'd0, dout}, 32'h11);

    // 6: reset with capture at level 5
    cnt_en = 1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("t6_level", {28'd0, level}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cnt_en = 1'($urandom_range(0, 1));
      cnt_ld = ($urandom_range(0, 15) == 0);
      cnt_ld_val = 8'($urandom());
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
